// File: rtl/bd_pkg.sv
// Shared encodings, widths and per-encoding geometry for the base-delta decompressor.
package bd_pkg;

  localparam int LINE_W    = 1024;
  localparam int CQ_W      = 644;
  localparam int MASK_LSB  = 576;
  localparam int ENC_LSB   = 640;
  localparam int PAYLOAD_W = MASK_LSB;
  localparam int MASK_W    = ENC_LSB - MASK_LSB;
  localparam int WAY_W     = 4;

  typedef enum logic [3:0] {
    ENC_ZEROS = 4'd0,
    ENC_REP8  = 4'd1,
    ENC_B8D1  = 4'd2,
    ENC_B8D2  = 4'd3,
    ENC_B8D4  = 4'd4,
    ENC_B4D1  = 4'd5,
    ENC_B4D2  = 4'd6,
    ENC_B2D1  = 4'd7
  } bd_enc_t;

  function automatic logic enc_is_bd(logic [3:0] enc);
    return enc inside {ENC_B8D1, ENC_B8D2, ENC_B8D4, ENC_B4D1, ENC_B4D2, ENC_B2D1};
  endfunction

  function automatic logic enc_is_illegal(logic [3:0] enc);
    return enc[3];
  endfunction

  // Element width E in bits.
  function automatic int elem_w(logic [3:0] enc);
    case (enc)
      ENC_B8D1, ENC_B8D2, ENC_B8D4: return 64;
      ENC_B4D1, ENC_B4D2:           return 32;
      ENC_B2D1:                     return 16;
      default:                      return 0;
    endcase
  endfunction

  function automatic int delta_w(logic [3:0] enc);
    case (enc)
      ENC_B8D1, ENC_B4D1, ENC_B2D1: return 8;
      ENC_B8D2, ENC_B4D2:           return 16;
      ENC_B8D4:                     return 32;
      default:                      return 0;
    endcase
  endfunction

  // Element count N = LINE_W / E; single-beat encodings report 1.
  function automatic int elem_count(logic [3:0] enc);
    case (enc)
      ENC_B8D1, ENC_B8D2, ENC_B8D4: return 16;
      ENC_B4D1, ENC_B4D2:           return 32;
      ENC_B2D1:                     return 64;
      default:                      return 1;
    endcase
  endfunction

endpackage

// File: rtl/bd_decompressor_if.sv
// Record-in / line-out handshake bundle; the decompressor is the slave side.
interface bd_decompressor_if;
  import bd_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CQ_W-1:0]     cq;
  logic [WAY_W-1:0]    way;
  logic                out_valid;
  logic                out_ready;
  logic [LINE_W-1:0]   line;
  logic [WAY_W-1:0]    way_out;
  logic                err;

  modport master (
    output in_valid, cq, way, out_ready,
    input  in_ready, out_valid, line, way_out, err
  );

  modport slave (
    input  in_valid, cq, way, out_ready,
    output in_ready, out_valid, line, way_out, err
  );

endinterface

// File: rtl/bd_lane_expand.sv
// One reconstruction lane: (mask ? base : 0) + sext(delta), modulo E, zero-extended to 64 bits.
module bd_lane_expand
  import bd_pkg::*;
(
  input  logic [3:0]  enc,
  input  logic [63:0] base,
  input  logic [31:0] delta,
  input  logic        mask_bit,
  output logic [63:0] result
);

  logic [63:0] base64;
  logic [31:0] base32;
  logic [15:0] base16;

  assign base64 = mask_bit ? base         : 64'd0;
  assign base32 = mask_bit ? base[31:0]   : 32'd0;
  assign base16 = mask_bit ? base[15:0]   : 16'd0;

  always_comb begin
    // NOTE: result gets a default before the case so no encoding leaves it unassigned (no latch).
    result = '0;
    case (enc)
      ENC_B8D1: result = base64 + {{56{delta[7]}},  delta[7:0]};
      ENC_B8D2: result = base64 + {{48{delta[15]}}, delta[15:0]};
      ENC_B8D4: result = base64 + {{32{delta[31]}}, delta[31:0]};
      ENC_B4D1: result = {32'd0, base32 + {{24{delta[7]}},  delta[7:0]}};
      ENC_B4D2: result = {32'd0, base32 + {{16{delta[15]}}, delta[15:0]}};
      ENC_B2D1: result = {48'd0, base16 + {{8{delta[7]}},   delta[7:0]}};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/bd_decompressor.sv
// Base-delta decompressor: captures one record, rebuilds the line LANES elements per beat,
// then holds it on a valid/ready output until consumed.
module bd_decompressor
  import bd_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic clk,
  input  logic reset,
  bd_decompressor_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]           state;
  logic [4:0]           beat;
  logic [4:0]           beats_total;
  logic [3:0]           enc_q;
  logic [MASK_W-1:0]    mask_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [LINE_W-1:0]    line_q;
  logic [WAY_W-1:0]     way_q;
  logic                 err_q;

  logic [3:0]           cq_enc;
  logic                 last_beat;

  logic [6:0]  lane_idx  [LANES];
  logic [31:0] lane_slot [LANES];
  logic        lane_we   [LANES];
  logic [63:0] lane_res  [LANES];

  assign cq_enc    = bus.cq[ENC_LSB +: 4];
  assign last_beat = (beat == beats_total - 5'd1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l]  = 7'(int'(beat) * LANES + l);
    assign lane_we[l]   = int'(lane_idx[l]) < elem_count(enc_q);
    // Each element's delta field starts right after the base, 8d bits per element.
    assign lane_slot[l] = 32'(payload_q >> (elem_w(enc_q) + int'(lane_idx[l]) * delta_w(enc_q)));

    bd_lane_expand u_lane (
      .enc      (enc_q),
      .base     (payload_q[63:0]),
      .delta    (lane_slot[l]),
      .mask_bit (mask_q[lane_idx[l][5:0]]),
      .result   (lane_res[l])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      beat        <= '0;
      beats_total <= 5'd1;
      enc_q       <= '0;
      mask_q      <= '0;
      payload_q   <= '0;
      // NOTE: the line is a plain register (not a RAM), so it takes a reset value like the rest.
      line_q      <= '0;
      way_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            enc_q       <= cq_enc;
            mask_q      <= bus.cq[MASK_LSB +: MASK_W];
            payload_q   <= bus.cq[PAYLOAD_W-1:0];
            way_q       <= bus.way;
            err_q       <= enc_is_illegal(cq_enc);
            line_q      <= '0;
            beat        <= '0;
            beats_total <= enc_is_bd(cq_enc) ? 5'(elem_count(cq_enc) / LANES) : 5'd1;
            state       <= S_EXPAND;
          end
        end

        S_EXPAND: begin
          // ZEROS and ILLEGAL rely on the clear done at capture.
          if (enc_q == ENC_REP8) begin
            line_q <= {(LINE_W/64){payload_q[63:0]}};
          end else if (enc_is_bd(enc_q)) begin
            for (int l = 0; l < LANES; l++) begin
              if (lane_we[l]) begin
                case (elem_w(enc_q))
                  64:      line_q[{lane_idx[l][3:0], 6'd0} +: 64] <= lane_res[l];
                  32:      line_q[{lane_idx[l][4:0], 5'd0} +: 32] <= lane_res[l][31:0];
                  default: line_q[{lane_idx[l][5:0], 4'd0} +: 16] <= lane_res[l][15:0];
                endcase
              end
            end
          end

          if (last_beat) begin
            state <= S_DONE;
          end else begin
            beat <= beat + 5'd1;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.line      = line_q;
  assign bus.way_out   = way_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bd_decompressor.sv
// Directed bench for bd_decompressor: table of hand-built records plus backpressure and reset sequences.
module tb_bd_decompressor;
  import bd_pkg::*;

  logic clk = 1'b0;
  logic reset;

  bd_decompressor_if bus ();

  bd_decompressor #(.LANES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]           enc;
    logic [63:0]          mask;
    logic [PAYLOAD_W-1:0] payload;
    logic [3:0]           way;
    logic                 early_ready;
    int                   lat;
    logic [LINE_W-1:0]    exp_line;
    logic                 exp_err;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
    int w;
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      w = 0;
      while (w < 15 && got[w*64 +: 64] === exp[w*64 +: 64]) w++;
      $display("FAIL %s word %0d got=%h expected=%h", name, w, got[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  function automatic logic [PAYLOAD_W-1:0] put_field(input logic [PAYLOAD_W-1:0] p,
                                                     input int lsb, input int w,
                                                     input logic [63:0] v);
    logic [PAYLOAD_W-1:0] r;
    r = p;
    for (int b = 0; b < w; b++) r[lsb + b] = v[b];
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] put_elem(input logic [LINE_W-1:0] l, input int e,
                                                 input int i, input logic [63:0] v);
    logic [LINE_W-1:0] r;
    r = l;
    for (int b = 0; b < e; b++) r[i*e + b] = v[b];
    return r;
  endfunction

  task automatic build_table();
    logic [PAYLOAD_W-1:0] p;
    logic [LINE_W-1:0]    l;

    // 0: B8D1, word i = base + i
    p = put_field('0, 0, 64, 64'h1000_0000_0000_0000);
    l = '0;
    for (int i = 0; i < 16; i++) begin
      p = put_field(p, 64 + i*8, 8, 64'(i));
      l = put_elem(l, 64, i, 64'h1000_0000_0000_0000 + 64'(i));
    end
    tbl[0] = '{ENC_B8D1, 64'hFFFF, p, 4'd5, 1'b0, 2, l, 1'b0};

    // 1: B2D1, mask 0, deltas 0x80 -> 0xFF80 everywhere; out_ready held high early
    p = put_field('0, 0, 16, 64'h1234);
    l = '0;
    for (int i = 0; i < 64; i++) begin
      p = put_field(p, 16 + i*8, 8, 64'h80);
      l = put_elem(l, 16, i, 64'hFF80);
    end
    tbl[1] = '{ENC_B2D1, 64'h0, p, 4'd3, 1'b1, 8, l, 1'b0};

    // 2: B4D2, alternating mask, deltas 0xFFFF
    p = put_field('0, 0, 32, 64'h0001_0000);
    l = '0;
    for (int i = 0; i < 32; i++) begin
      p = put_field(p, 32 + i*16, 16, 64'hFFFF);
      l = put_elem(l, 32, i, (i % 2 == 0) ? 64'h0000_FFFF : 64'hFFFF_FFFF);
    end
    tbl[2] = '{ENC_B4D2, 64'h5555_5555_5555_5555, p, 4'hA, 1'b0, 4, l, 1'b0};

    // 3: REP8, garbage above the first word must not leak in
    p = put_field('0, 0, 64, 64'hDEAD_BEEF_CAFE_F00D);
    p = put_field(p, 100, 32, 64'hFFFF_0000);
    l = '0;
    for (int i = 0; i < 16; i++) l = put_elem(l, 64, i, 64'hDEAD_BEEF_CAFE_F00D);
    tbl[3] = '{ENC_REP8, 64'h0, p, 4'hF, 1'b0, 1, l, 1'b0};

    // 4: illegal encoding 0xA -> zero line, err
    tbl[4] = '{4'hA, '1, p, 4'd9, 1'b0, 1, '0, 1'b1};

    // 5: ZEROS with a busy payload and mask
    tbl[5] = '{ENC_ZEROS, '1, p, 4'd1, 1'b1, 1, '0, 1'b0};

    // 6: B2D1 wrap at element 0 and last element 63
    p = put_field('0, 0, 16, 64'hFFFF);
    p = put_field(p, 16, 8, 64'h01);
    p = put_field(p, 16 + 63*8, 8, 64'h7F);
    l = '0;
    l = put_elem(l, 16, 63, 64'h007E);
    tbl[6] = '{ENC_B2D1, 64'h8000_0000_0000_0001, p, 4'd6, 1'b0, 8, l, 1'b0};

    // 7: B8D4, negative and large positive delta; mask bits >= 16 ignored
    p = put_field('0, 0, 64, 64'd5);
    p = put_field(p, 64, 32, 64'hFFFF_FFFF);
    p = put_field(p, 64 + 15*32, 32, 64'h7FFF_FFFF);
    l = '0;
    l = put_elem(l, 64, 0, 64'd4);
    l = put_elem(l, 64, 15, 64'h0000_0000_8000_0004);
    tbl[7] = '{ENC_B8D4, 64'hFFFF_0000_0000_8001, p, 4'd7, 1'b0, 2, l, 1'b0};

    // 8: B4D1, element i = 0x80000000 + i
    p = put_field('0, 0, 32, 64'h8000_0000);
    l = '0;
    for (int i = 0; i < 32; i++) begin
      p = put_field(p, 32 + i*8, 8, 64'(i));
      l = put_elem(l, 32, i, 64'h8000_0000 + 64'(i));
    end
    tbl[8] = '{ENC_B4D1, '1, p, 4'd2, 1'b0, 4, l, 1'b0};

    // 9: B8D2, mask 0, deltas 0x8000 sign-extend to 64 bits
    p = put_field('0, 0, 64, 64'h1111);
    l = '0;
    for (int i = 0; i < 16; i++) begin
      p = put_field(p, 64 + i*16, 16, 64'h8000);
      l = put_elem(l, 64, i, 64'hFFFF_FFFF_FFFF_8000);
    end
    tbl[9] = '{ENC_B8D2, 64'h0, p, 4'd4, 1'b0, 2, l, 1'b0};
  endtask

  // Count edges after the accept edge until out_valid; 20 is the give-up bound.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.cq       = {v.enc, v.mask, v.payload};
    bus.way      = v.way;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (v.early_ready) bus.out_ready = 1'b1;
    check({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    wait_valid(cyc);
    check({tag, ".latency"}, 64'(cyc), 64'(v.lat));
    check_line({tag, ".line"}, bus.line, v.exp_line);
    check({tag, ".way_out"}, 64'(bus.way_out), 64'(v.way));
    check({tag, ".err"}, 64'(bus.err), 64'(v.exp_err));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic saw_valid;

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.cq        = '0;
    bus.way       = '0;
    build_table();

    repeat (3) @(negedge clk);
    check("rst.in_ready",  64'(bus.in_ready),  64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check_line("rst.line", bus.line, '0);
    check("rst.way_out",   64'(bus.way_out),   64'd0);
    check("rst.err",       64'(bus.err),       64'd0);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: second record presented throughout, must wait for the handshake.
    @(negedge clk);
    bus.cq       = {tbl[0].enc, tbl[0].mask, tbl[0].payload};
    bus.way      = tbl[0].way;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.cq  = {tbl[3].enc, tbl[3].mask, tbl[3].payload};
    bus.way = tbl[3].way;
    wait_valid(cyc);
    check("bp.latency", 64'(cyc), 64'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_line("bp.line_stable", bus.line, tbl[0].exp_line);
      check("bp.way_stable",  64'(bus.way_out),   64'd5);
      check("bp.out_valid",   64'(bus.out_valid), 64'd1);
      check("bp.in_ready",    64'(bus.in_ready),  64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp.idle_after_hs", 64'(bus.in_ready),  64'd1);
    check("bp.valid_drop",    64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.second_accept", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("bp.second_valid", 64'(bus.out_valid), 64'd1);
    check_line("bp.second_line", bus.line, tbl[3].exp_line);
    check("bp.second_way", 64'(bus.way_out), 64'hF);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in EXPAND beat 1 of a B4D1 record.
    @(negedge clk);
    bus.cq       = {tbl[8].enc, tbl[8].mask, tbl[8].payload};
    bus.way      = tbl[8].way;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst.out_valid", 64'(bus.out_valid), 64'd0);
    check("arst.in_ready",  64'(bus.in_ready),  64'd1);
    check_line("arst.line", bus.line, '0);
    check("arst.way_out",   64'(bus.way_out),   64'd0);
    check("arst.err",       64'(bus.err),       64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("arst.no_output", 64'(saw_valid), 64'd0);
    run_vec(tbl[8], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bd_decompressor.md
# bd_decompressor

Base-delta decompression stage. It accepts one compressed cache-line record (4-bit encoding, 64-bit base-select mask, 576-bit base+delta payload) and the associated way index. It rebuilds the 1024-bit uncompressed line over several clock beats and presents the line to the cache fill/read path with a valid/ready handshake. It sits directly downstream of `compressor` and consumes its `cq`/`way` outputs on the read-hit path.

## Interface
- `LANES`, default 8: elements reconstructed per beat. Legal values are 4, 8, 16.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `cq`/`way` hold a record.
- `in_ready`  out  1  block can accept a record.
- `cq`  in  644  compressed record: [643:640] encoding, [639:576] mask, [575:0] payload.
- `way`  in  4  way index; carried alongside the data.
- `out_valid`  out  1  `line`/`way_out`/`err` are valid.
- `out_ready`  in  1  consumer accepts the output.
- `line`  out  1024  reconstructed line. Element i occupies bits [i*E +: E], where E = element width in bits.
- `way_out`  out  4  captured `way`.
- `err`  out  1  illegal encoding was received.

## Operation
- Encodings: 0 ZEROS, 1 REP8, 2 B8D1, 3 B8D2, 4 B8D4, 5 B4D1, 6 B4D2, 7 B2D1. Encodings 8–15 are ILLEGAL.
- For BbDd encodings:
  - Element width E = 8b bits; element count N = 128/b (16, 32 or 64).
  - Base occupies payload[E-1:0].
  - Delta i occupies payload[E + i*8d +: 8d].
- Element i = (mask[i] ? base : 0) + sext(delta_i). Arithmetic is modulo 2^E; no carry between elements.
- Mask bits at index N and above are ignored.
- REP8: all 16 64-bit words equal payload[63:0].
- ZEROS: line is all zeros.
- ILLEGAL: line is 0 and err = 1. For all legal encodings err = 0.
- FSM states:
  - IDLE: `in_ready` = 1.
    - On `in_valid && in_ready`: capture `cq` and `way`, clear `line`, set beat = 0, set beats_total, go to EXPAND.
  - EXPAND: each edge writes elements [beat*LANES, (beat+1)*LANES) of the line.
    - ZEROS, REP8 and ILLEGAL write the whole line in one beat.
    - beats_total = N/LANES for BbDd encodings, otherwise 1.
    - After the final beat: go to DONE.
  - DONE: `out_valid` = 1.
    - On `out_valid && out_ready`: go to IDLE.
- `in_ready` is low in EXPAND and DONE. Inputs outside IDLE are ignored and not queued.
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `line` 0, `way_out` 0, `err` 0, beat 0.

## Timing
- Accept edge = edge 0. `out_valid` rises after edge beats_total.
- With LANES = 8:
  - B8* formats: 2 beats.
  - B4* formats: 4 beats.
  - B2D1: 8 beats.
  - ZEROS, REP8, ILLEGAL: 1 beat.
- `line`, `way_out` and `err` are registered and stable for as long as `out_valid` is high. Backpressure on `out_ready` stalls indefinitely.
- The output handshake edge returns the block to IDLE. `in_ready` = 1 in the following cycle, so the earliest next accept is the cycle after the handshake. Minimum spacing between accepts is beats_total + 2 cycles.
- `out_ready` asserted while `out_valid` is low has no effect.
- Reset asserted in any state aborts the record at once: no output is produced and all outputs take their reset values asynchronously.
- Deltas that overflow wrap silently. Example: B2D1 with base 0xFFFF, mask 1, delta 0x01 gives 0x0000.

## Structure
- Package `bd_pkg` holds:
  - the encoding enum `bd_enc_t`;
  - `LINE_W` = 1024, `CQ_W` = 644, `MASK_LSB` = 576, `ENC_LSB` = 640;
  - per-encoding constants for E, delta width and N, as functions or lookup constants.
- Sub-module `bd_lane_expand` (combinational) maps base, one 32-bit delta slot, mask bit and encoding to one 64-bit lane result, zero-extended for narrower E. The top instantiates it LANES times.
- Top-level contents: FSM, beat counter, capture registers and line register write-enable per lane.

## Test plan
- B8D1: base 0x1000000000000000, mask 0xFFFF, deltas 0x00..0x0F, `way` 5 → word i = base + i. `out_valid` after edge 2; `way_out` = 5; `err` = 0.
- B2D1: mask 0, all deltas 0x80 → every 16-bit element = 0xFF80. `out_valid` after edge 8 (LANES = 8).
- B4D2: base 0x00010000, mask alternating 1/0, deltas 0xFFFF → even elements 0x0000FFFF, odd elements 0xFFFFFFFF.
- REP8 with payload 0xDEADBEEFCAFEF00D; then encoding 0xA → line = 16 copies of that word; then line = 0, `err` = 1, each with `out_valid` after edge 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles with `in_valid` high → outputs stable, `in_ready` = 0, second record not accepted until the cycle after the handshake.
- Drive `reset` low during EXPAND beat 1 of a B4D1 record → `out_valid` stays 0, state IDLE, `line` = 0; a fresh record after release decodes correctly.
